// File: rtl/system_x_pkg.sv
// Shared types and truth-table masks for the 2-bit magnitude comparator.
// Bit i of each mask is the flag value for table index {A,B,C,D} = i.
package system_x_pkg;

    localparam logic [15:0] GT_MASK = 16'h7310;
    localparam logic [15:0] EQ_MASK = 16'h8421;

    typedef logic [1:0] operand_t;

endpackage

// File: rtl/system_x_if.sv
// Operand/result bundle for system_x.
// y_count exists only when SYSTEMX_STATS_EN is defined.
interface system_x_if;

    logic A;
    logic B;
    logic C;
    logic D;
    logic Y;
    logic eq;
    logic lt;
`ifdef SYSTEMX_STATS_EN
    logic [15:0] y_count;
`endif

    modport master (
        output A, B, C, D,
`ifdef SYSTEMX_STATS_EN
        input  y_count,
`endif
        input  Y, eq, lt
    );

    modport slave (
        input  A, B, C, D,
`ifdef SYSTEMX_STATS_EN
        output y_count,
`endif
        output Y, eq, lt
    );

endinterface

// File: rtl/system_x_cmp2.sv
// Combinational 2-bit unsigned comparator driven by the package truth-table masks.
// Exactly one of gt/eq/lt is high for any known input.
module system_x_cmp2
    import system_x_pkg::*;
(
    input  operand_t x,
    input  operand_t z,
    output logic     gt,
    output logic     eq,
    output logic     lt
);

    logic [3:0] idx;

    assign idx = {x, z};
    assign gt  = GT_MASK[idx];
    assign eq  = EQ_MASK[idx];
    assign lt  = ~(gt | eq);

endmodule

// File: rtl/system_x.sv
// Registered 2-bit magnitude comparator: X={A,B} vs Z={C,D}, one-cycle latency.
// Define SYSTEMX_STATS_EN to add a saturating count of cycles with Y high.
module system_x
    import system_x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    system_x_if.slave   bus
);

    logic gt_c;
    logic eq_c;
    logic lt_c;
    logic y_q;
    logic eq_q;
    logic lt_q;

    system_x_cmp2 u_cmp (
        .x  ({bus.A, bus.B}),
        .z  ({bus.C, bus.D}),
        .gt (gt_c),
        .eq (eq_c),
        .lt (lt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            y_q  <= gt_c;
            eq_q <= eq_c;
            lt_q <= lt_c;
        end
    end

    assign bus.Y  = y_q;
    assign bus.eq = eq_q;
    assign bus.lt = lt_q;

`ifdef SYSTEMX_STATS_EN
    logic [15:0] cnt_q;

    // Counts edges where the registered Y is already high; holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (y_q && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign bus.y_count = cnt_q;
`endif

endmodule

// File: tb/tb_system_x.sv
// Scoreboard bench for system_x: sweep, glitch, async reset, hold and optional stats.
// Build with SYSTEMX_STATS_EN defined to exercise y_count.
module tb_system_x;
    import system_x_pkg::*;

    typedef struct packed {
        logic [3:0] idx;
        logic       gt;
        logic       eq;
        logic       lt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    exp_t sb_q[$];

    system_x_if bus ();

    system_x dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {bus.A, bus.B, bus.C, bus.D} = v;
    endtask

    function automatic exp_t model(input logic [3:0] v);
        exp_t e;
        e.idx = v;
        e.gt  = v[3:2] > v[1:0];
        e.eq  = v[3:2] == v[1:0];
        e.lt  = v[3:2] < v[1:0];
        return e;
    endfunction

    // Drive after a falling edge, queue the expectation, check the comb stage.
    task automatic step(input logic [3:0] v);
        logic [15:0] gm;
        logic [15:0] em;
        gm = GT_MASK;
        em = EQ_MASK;
        @(negedge clk);
        #1;
        drive(v);
        sb_q.push_back(model(v));
        #1;
        chk("cmp_gt", {31'd0, dut.u_cmp.gt}, {31'd0, gm[v]});
        chk("cmp_eq", {31'd0, dut.u_cmp.eq}, {31'd0, em[v]});
        chk("cmp_lt", {31'd0, dut.u_cmp.lt}, {31'd0, ~(gm[v] | em[v])});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("reg_y", {31'd0, bus.Y}, {31'd0, e.gt});
            chk("reg_eq", {31'd0, bus.eq}, {31'd0, e.eq});
            chk("reg_lt", {31'd0, bus.lt}, {31'd0, e.lt});
            chk("onehot", $countones({bus.Y, bus.eq, bus.lt}), 1);
        end
    end

`ifdef SYSTEMX_STATS_EN
    logic        m_y = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_y   <= 1'b0;
            m_cnt <= 16'h0000;
        end else begin
            if (m_y && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'h0001;
            m_y <= ({bus.A, bus.B} > {bus.C, bus.D});
        end
    end
`endif

    initial begin
        #1_500_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        drive(4'b1000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_y", {31'd0, bus.Y}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_y", {31'd0, bus.Y}, 0);
        chk("arst_eq", {31'd0, bus.eq}, 0);
        chk("arst_lt", {31'd0, bus.lt}, 0);
`ifdef SYSTEMX_STATS_EN
        chk("arst_cnt", {16'd0, bus.y_count}, 0);
`endif
        @(posedge clk);
        #1;
        chk("rst_hold_y", {31'd0, bus.Y}, 0);
        drive(4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) step(4'(i));
        step(4'b0000);
        step(4'b0000);
`ifdef SYSTEMX_STATS_EN
        chk("sweep_cnt", {16'd0, bus.y_count}, 6);
        begin
            int g;
            g = 0;
            while (m_cnt != 16'hFFFE && g < 70000) begin
                step(4'b0100);
                g++;
            end
            chk("sat_bound", (g < 70000) ? 1 : 0, 1);
        end
        chk("cnt_fffe", {16'd0, bus.y_count}, 32'hFFFE);
        repeat (3) step(4'b0100);
        chk("cnt_sat", {16'd0, bus.y_count}, 32'hFFFF);
        repeat (2) step(4'b0100);
        chk("cnt_hold", {16'd0, bus.y_count}, 32'hFFFF);
`endif

        step(4'b0100);
        step(4'b0100);
        @(posedge clk);
        #2;
        drive(4'b0001);
        #1;
        chk("glitch_y", {31'd0, bus.Y}, 1);
        #1;
        drive(4'b0100);
        step(4'b0100);

        @(negedge clk);
        #1;
        chk("pre_arst_y", {31'd0, bus.Y}, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_y", {31'd0, bus.Y}, 0);
        chk("mid_rst_eq", {31'd0, bus.eq}, 0);
        chk("mid_rst_lt", {31'd0, bus.lt}, 0);
`ifdef SYSTEMX_STATS_EN
        chk("mid_rst_cnt", {16'd0, bus.y_count}, 0);
`endif
        drive(4'b1110);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_y", {31'd0, bus.Y}, 1);
        chk("post_rst_eq", {31'd0, bus.eq}, 0);
        chk("post_rst_lt", {31'd0, bus.lt}, 0);

        repeat (5) step(4'b1111);
        step(4'b0000);
        @(negedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
